// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 16/8 signed divider.
// Holds the state encoding, operand widths and sign-correction helpers.
package div_pkg;

  localparam int DVD_W   = 16;
  localparam int DVS_W   = 8;
  localparam int N_STEPS = 16;
  localparam logic [3:0] LAST_STEP = 4'(N_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement negate when neg is set; -32768 maps onto itself.
  function automatic logic [DVD_W-1:0] cond_neg16(input logic neg, input logic [DVD_W-1:0] v);
    return neg ? (~v + 16'd1) : v;
  endfunction

  function automatic logic [DVS_W-1:0] cond_neg8(input logic neg, input logic [DVS_W-1:0] v);
    return neg ? (~v + 8'd1) : v;
  endfunction

endpackage

// File: rtl/div_step_16x8.sv
// One restoring division step: shift in a dividend bit, trial-subtract the
// divisor magnitude, keep the difference if it did not go negative.
module div_step_16x8
  import div_pkg::*;
(
  input  logic [8:0]       prem,
  input  logic             next_bit,
  input  logic [DVS_W-1:0] dvs_mag,
  output logic [8:0]       prem_next,
  output logic             q_bit
);

  logic [9:0] shifted_s;
  logic       fits_s;

  assign shifted_s = {prem, next_bit};
  assign fits_s    = (shifted_s >= {2'b00, dvs_mag});
  assign q_bit     = fits_s;
  assign prem_next = fits_s ? 9'(shifted_s - {2'b00, dvs_mag}) : shifted_s[8:0];

endmodule

// File: rtl/div_seq_16x8_2sc.sv
// Sequential signed 16/8 divider: sign-magnitude restoring division, one
// quotient bit per cycle, valid/ready on both operand and result sides.
module div_seq_16x8_2sc
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  state_t           state_r, state_s;
  logic [DVD_W-1:0] dvd_mag_r;
  logic [DVD_W-1:0] q_mag_r;
  logic [DVS_W-1:0] dvs_mag_r;
  logic [8:0]       prem_r;
  logic [8:0]       prem_next_s;
  logic             q_bit_s;
  logic [3:0]       cnt_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             ovf_pend_r;

  assign in_ready = (state_r == IDLE);

  div_step_16x8 u_step (
    .prem      (prem_r),
    .next_bit  (dvd_mag_r[DVD_W-1]),
    .dvs_mag   (dvs_mag_r),
    .prem_next (prem_next_s),
    .q_bit     (q_bit_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a zero divisor bypasses the iteration entirely.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = (divisor == 8'd0) ? DONE : DIV;
        end else begin
          state_s = IDLE;
        end
      end
      DIV: begin
        if (cnt_r == LAST_STEP) begin
          state_s = FIX;
        end else begin
          state_s = DIV;
        end
      end
      FIX:  state_s = DONE;
      DONE: begin
        if (out_valid && out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd_mag_r   <= 16'd0;
      q_mag_r     <= 16'd0;
      dvs_mag_r   <= 8'd0;
      prem_r      <= 9'd0;
      cnt_r       <= 4'd0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      ovf_pend_r  <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= 16'd0;
      remainder   <= 8'd0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            dvd_mag_r  <= cond_neg16(dividend[DVD_W-1], dividend);
            dvs_mag_r  <= cond_neg8(divisor[DVS_W-1], divisor);
            neg_q_r    <= dividend[DVD_W-1] ^ divisor[DVS_W-1];
            neg_r_r    <= dividend[DVD_W-1];
            ovf_pend_r <= (dividend == 16'h8000) && (divisor == 8'hFF);
            cnt_r      <= 4'd0;
            prem_r     <= 9'd0;
            q_mag_r    <= 16'd0;
          end
        end
        DIV: begin
          dvd_mag_r <= {dvd_mag_r[DVD_W-2:0], 1'b0};
          prem_r    <= prem_next_s;
          q_mag_r   <= {q_mag_r[DVD_W-2:0], q_bit_s};
          cnt_r     <= cnt_r + 4'd1;
        end
        FIX: begin
          quotient    <= cond_neg16(neg_q_r, q_mag_r);
          remainder   <= cond_neg8(neg_r_r && (prem_r[7:0] != 8'd0), prem_r[7:0]);
          overflow    <= ovf_pend_r;
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
        end
        DONE: begin
          // Entering DONE with no valid result only happens on a zero divisor.
          if (!out_valid) begin
            quotient    <= 16'd0;
            remainder   <= 8'd0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
            out_valid   <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_16x8_2sc.sv
// Directed self-checking bench for div_seq_16x8_2sc with hand-computed
// quotients, remainders, flags and handshake latencies.
module tb_div_seq_16x8_2sc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  div_seq_16x8_2sc dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for exactly one accepting edge, then scramble them.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'h5A5A;
    divisor  = 8'h33;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) chk("timeout_out_valid", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er,
                        input logic edbz, input logic eovf, input int elat);
    int lat;
    start_op(a, b);
    wait_out(lat);
    chk({name, "_lat"}, 32'(lat), 32'(elat));
    chk({name, "_q"}, 32'(quotient), 32'(eq));
    chk({name, "_r"}, 32'(remainder), 32'(er));
    chk({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    chk({name, "_ovf"}, 32'(overflow), 32'(eovf));
    chk({name, "_busy"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({name, "_consumed"}, 32'(out_valid), 32'd0);
    chk({name, "_back_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int stale;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = 16'd0;
    divisor   = 8'd0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_q", 32'(quotient), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("p100_7",    16'h0064, 8'h07, 16'h000E, 8'h02, 1'b0, 1'b0, 17);
    run_op("n100_7",    16'hFF9C, 8'h07, 16'hFFF2, 8'hFE, 1'b0, 1'b0, 17);
    run_op("n100_n7",   16'hFF9C, 8'hF9, 16'h000E, 8'hFE, 1'b0, 1'b0, 17);
    run_op("min_n1",    16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 1'b1, 17);
    run_op("min_n128",  16'h8000, 8'h80, 16'h0100, 8'h00, 1'b0, 1'b0, 17);
    run_op("dbz",       16'h04D2, 8'h00, 16'h0000, 8'h00, 1'b1, 1'b0, 1);
    run_op("p127_n128", 16'h007F, 8'h80, 16'h0000, 8'h7F, 1'b0, 1'b0, 17);
    run_op("n1_2",      16'hFFFF, 8'h02, 16'h0000, 8'hFF, 1'b0, 1'b0, 17);
    run_op("max_1",     16'h7FFF, 8'h01, 16'h7FFF, 8'h00, 1'b0, 1'b0, 17);

    // Backpressure with a stray in_valid pulse during the iteration.
    out_ready = 1'b0;
    start_op(16'd1000, 8'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 16'd7;
    divisor  = 8'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_q", 32'(quotient), 32'h006F);
    chk("bp_r", 32'(remainder), 32'h01);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_q", 32'(quotient), 32'h006F);
      chk("bp_hold_busy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_released", 32'(in_ready), 32'd1);
    run_op("after_bp", 16'd7, 8'd1, 16'h0007, 8'h00, 1'b0, 1'b0, 17);

    // Asynchronous reset in the middle of the iteration.
    start_op(16'h0064, 8'h07);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_q", 32'(quotient), 32'd0);
    chk("midrst_r", 32'(remainder), 32'd0);
    chk("midrst_flags", 32'({div_by_zero, overflow}), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    stale = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    chk("no_stale_valid", 32'(stale), 32'd0);
    run_op("post_rst", 16'h0064, 8'h07, 16'h000E, 8'h02, 1'b0, 1'b0, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq_16x8_2sc.md
# div_seq_16x8_2sc

Sequential signed divider, the inverse of the team's pipelined 8x8 two's-complement multiplier. It divides a 16-bit two's-complement dividend by an 8-bit two's-complement divisor and returns a 16-bit quotient truncated toward zero plus an 8-bit remainder. It uses sign-magnitude restoring division at one quotient bit per cycle, with valid/ready handshakes on both sides. It sits alongside the multiplier in the arithmetic library and recovers operands from products (y / b -> a).

## Interface
- No parameters. Widths are fixed: dividend 16, divisor 8, quotient 16, remainder 8.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block idle and able to accept operands
- dividend  in  16  two's-complement dividend
- divisor  in  8  two's-complement divisor
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts the result
- quotient  out  16  two's-complement quotient, truncated toward zero
- remainder  out  8  two's-complement remainder; sign follows the dividend, or 0
- div_by_zero  out  1  divisor was 0 (qualified by out_valid)
- overflow  out  1  operation was -32768 / -1 (qualified by out_valid)

## Operation
- FSM states: IDLE, DIV, FIX, DONE.
  - in_ready = (state == IDLE). It is combinational and registered-free.
- IDLE, when in_valid is high:
  - Capture operands.
  - Compute magnitudes: dividend magnitude is 16-bit unsigned (|-32768| = 32768); divisor magnitude is 8-bit unsigned (|-128| = 128).
  - Capture the sign flags: neg_q = dividend[15] ^ divisor[7] and neg_r = dividend[15].
  - Clear the iteration counter and go to DIV.
- IDLE with divisor == 0:
  - Go straight to DONE.
  - quotient = 0, remainder = 0, div_by_zero = 1, overflow = 0.
- DIV: one restoring step per cycle, MSB first, for 16 cycles.
  - Partial remainder is 9 bits.
  - Shift in the next dividend bit, then do a trial subtract of the divisor magnitude.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore it and set the bit to 0.
  - After the 16th step, go to FIX.
- FIX:
  - quotient = neg_q ? -q_mag : q_mag, taken mod 2^16.
  - remainder = (neg_r && r_mag != 0) ? -r_mag : r_mag.
  - r_mag is at most 127, so the result fits signed 8 bits.
  - overflow = (dividend == 16'h8000 && divisor == 8'hFF). The quotient wraps to 16'h8000.
  - Go to DONE.
- DONE:
  - out_valid = 1.
  - Hold quotient, remainder and flags stable until out_ready is high, then go to IDLE.
- in_valid is ignored outside IDLE. Operands need only be stable in the accepting cycle.

## Timing
- Handshake at edge T (in_valid and in_ready both high), normal operation:
  - DIV steps occur at edges T+1..T+16.
  - FIX occurs at edge T+17; out_valid rises after edge T+17. Latency is 17 cycles.
- Divide by zero: out_valid rises after edge T+1.
- If out_ready is already high when out_valid rises, the result is consumed at the next edge. The block is back in IDLE (in_ready = 1) one cycle after out_valid rises.
- Throughput is one division per 19 cycles at minimum, with no overlap.
- Reset asserted (low), at any time including mid-DIV:
  - State returns to IDLE immediately and asynchronously.
  - out_valid = 0; quotient, remainder, div_by_zero and overflow = 0.
  - in_ready = 1.
  - The operation in progress is discarded and no result is emitted.
- All outputs except in_ready are registered.

## Structure
- Package div_pkg:
  - State encoding constants: IDLE = 2'd0, DIV = 2'd1, FIX = 2'd2, DONE = 2'd3.
  - Width constants: DVD_W = 16, DVS_W = 8.
  - Iteration count: N_STEPS = 16.
- Sub-module div_step_16x8 holds the combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder and quotient bit.
  - The top level instantiates it once and iterates it.

## Test plan
- 100 / 7 (16'h0064, 8'h07) -> quotient 16'h000E, remainder 8'h02, flags 0, out_valid 17 cycles after accept.
- -100 / 7 (16'hFF9C, 8'h07) -> quotient 16'hFFF2, remainder 8'hFE. Same operands with divisor -7 -> quotient 16'h000E, remainder 8'hFE.
- -32768 / -1 (16'h8000, 8'hFF) -> quotient 16'h8000, remainder 0, overflow 1. -32768 / -128 (8'h80) -> quotient 16'h0100, remainder 0, overflow 0.
- 1234 / 0 -> div_by_zero 1, quotient 0, remainder 0, out_valid 1 cycle after accept.
- Backpressure: out_ready held low for 5 cycles after out_valid -> outputs stable and in_ready low throughout. in_valid pulsed during DIV is ignored. Accept, then the next operation starts.
- Reset pulsed low at DIV step 8 -> all outputs 0 and in_ready 1 immediately, no stale out_valid. A fresh 100 / 7 after release gives the correct result.
